// File: rtl/uart_core_param.sv
// uart_core_param
//   Parametrised full-duplex UART. The transmitter takes a word through a
//   valid/ready handshake and serialises it LSB first, with optional parity
//   and one or two stop bits. The receiver synchronises the asynchronous
//   line, samples each bit in the middle, and reports parity and framing
//   errors alongside each received word.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate; one bit lasts CLK_FREQ/BAUD clocks
//   DATA_BITS  payload bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  transmitted stop bits (1..2); the receiver checks the first
//
// Ports
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   tx_data_i        word to send, captured on the handshake
//   tx_valid_i       client has a word to send
//   tx_ready_o       transmitter idle and accepting a word
//   tx_o             serial output, idles high
//   rx_i             serial input, asynchronous to clk_i
//   rx_data_o        last received word, held until the next frame
//   rx_valid_o       one-clock pulse per completed frame
//   rx_parity_err_o  parity mismatch on the last frame
//   rx_frame_err_o   first stop bit of the last frame sampled low

module uart_core_param #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o
);

  localparam int BIT_TICKS  = CLK_FREQ / BAUD;
  localparam int HALF       = BIT_TICKS / 2;
  localparam int STOP_TICKS = STOP_BITS * BIT_TICKS;
  localparam int CNT_W      = $clog2(STOP_TICKS + 1);
  localparam bit HAS_PAR    = (PARITY != 0);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);
  localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);

  // Refuse to build configurations the bit timing cannot support.
  if (BIT_TICKS < 4) begin : gBadBaud
    $error("uart_core_param: CLK_FREQ/BAUD must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_core_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : gBadParity
    $error("uart_core_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStop
    $error("uart_core_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  state_t                 txState_q;
  logic [CNT_W-1:0]       txCnt_q;
  logic [CNT_W-1:0]       txCnt_d;
  logic [3:0]             txIdx_q;
  logic [DATA_BITS-1:0]   txShift_q;
  logic                   txPar_q;
  logic                   tx_q;
  logic                   txReady_q;

  assign txCnt_d = txCnt_q + 1'b1;

  // The transmit FSM drives tx_q one clock ahead of each bit boundary so
  // the line is a clean register output. The parity bit is computed when
  // the word is captured, so it is ready before the data bits run out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txState_q <= S_IDLE;
      txCnt_q   <= '0;
      txIdx_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      tx_q      <= 1'b1;
      txReady_q <= 1'b1;
    end else begin
      case (txState_q)
        S_IDLE: begin
          if (tx_valid_i && txReady_q) begin
            txShift_q <= tx_data_i;
            txPar_q   <= (PARITY == 2) ? ^tx_data_i : ~^tx_data_i;
            txReady_q <= 1'b0;
            tx_q      <= 1'b0;
            txCnt_q   <= '0;
            txState_q <= S_START;
          end
        end
        S_START: begin
          if (txCnt_q == BIT_LAST) begin
            txCnt_q   <= '0;
            txIdx_q   <= '0;
            tx_q      <= txShift_q[0];
            txState_q <= S_DATA;
          end else begin
            txCnt_q <= txCnt_d;
          end
        end
        S_DATA: begin
          if (txCnt_q == BIT_LAST) begin
            txCnt_q <= '0;
            if (txIdx_q == IDX_LAST) begin
              if (HAS_PAR) begin
                tx_q      <= txPar_q;
                txState_q <= S_PARITY;
              end else begin
                tx_q      <= 1'b1;
                txState_q <= S_STOP;
              end
            end else begin
              txIdx_q   <= txIdx_q + 1'b1;
              txShift_q <= txShift_q >> 1;
              tx_q      <= txShift_q[1];
            end
          end else begin
            txCnt_q <= txCnt_d;
          end
        end
        S_PARITY: begin
          if (txCnt_q == BIT_LAST) begin
            txCnt_q   <= '0;
            tx_q      <= 1'b1;
            txState_q <= S_STOP;
          end else begin
            txCnt_q <= txCnt_d;
          end
        end
        S_STOP: begin
          if (txCnt_q == STOP_LAST) begin
            txCnt_q   <= '0;
            txReady_q <= 1'b1;
            txState_q <= S_IDLE;
          end else begin
            txCnt_q <= txCnt_d;
          end
        end
        default: begin
          txState_q <= S_IDLE;
          tx_q      <= 1'b1;
          txReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = txReady_q;

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  logic rxMeta_q;
  logic rxSync_q;

  // Two-flop synchroniser; both flops reset to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
    end
  end

  state_t                 rxState_q;
  logic [CNT_W-1:0]       rxCnt_q;
  logic [CNT_W-1:0]       rxCnt_d;
  logic [3:0]             rxIdx_q;
  logic [DATA_BITS-1:0]   rxShift_q;
  logic                   rxParBit_q;
  logic                   rxArmed_q;
  logic                   rxDone_q;
  logic                   rxValid_q;
  logic [DATA_BITS-1:0]   rxData_q;
  logic                   rxParErr_q;
  logic                   rxFrameErr_q;
  logic                   rxParExp;

  assign rxCnt_d  = rxCnt_q + 1'b1;
  assign rxParExp = (PARITY == 2) ? ^rxShift_q : ~^rxShift_q;

  // The receive FSM only arms after the synchronised line has been seen
  // high, so a line held low after a frame (break) produces a single
  // frame. The start bit is re-checked half a bit in to reject glitches,
  // after which every sample falls one full bit later, near mid-bit.
  // Results land on the stop sample and rx_valid follows one clock later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxState_q    <= S_IDLE;
      rxCnt_q      <= '0;
      rxIdx_q      <= '0;
      rxShift_q    <= '0;
      rxParBit_q   <= 1'b0;
      rxArmed_q    <= 1'b0;
      rxDone_q     <= 1'b0;
      rxValid_q    <= 1'b0;
      rxData_q     <= '0;
      rxParErr_q   <= 1'b0;
      rxFrameErr_q <= 1'b0;
    end else begin
      rxDone_q  <= 1'b0;
      rxValid_q <= rxDone_q;
      case (rxState_q)
        S_IDLE: begin
          if (!rxArmed_q) begin
            rxArmed_q <= rxSync_q;
          end else if (!rxSync_q) begin
            rxArmed_q <= 1'b0;
            rxCnt_q   <= '0;
            rxState_q <= S_START;
          end
        end
        S_START: begin
          if (rxCnt_q == HALF_LAST) begin
            rxCnt_q <= '0;
            rxIdx_q <= '0;
            if (rxSync_q) begin
              rxState_q <= S_IDLE;
            end else begin
              rxState_q <= S_DATA;
            end
          end else begin
            rxCnt_q <= rxCnt_d;
          end
        end
        S_DATA: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
            if (rxIdx_q == IDX_LAST) begin
              rxState_q <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              rxIdx_q <= rxIdx_q + 1'b1;
            end
          end else begin
            rxCnt_q <= rxCnt_d;
          end
        end
        S_PARITY: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q    <= '0;
            rxParBit_q <= rxSync_q;
            rxState_q  <= S_STOP;
          end else begin
            rxCnt_q <= rxCnt_d;
          end
        end
        S_STOP: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q      <= '0;
            rxData_q     <= rxShift_q;
            rxFrameErr_q <= ~rxSync_q;
            rxParErr_q   <= HAS_PAR && (rxParBit_q != rxParExp);
            rxDone_q     <= 1'b1;
            rxState_q    <= S_IDLE;
          end else begin
            rxCnt_q <= rxCnt_d;
          end
        end
        default: begin
          rxState_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data_o       = rxData_q;
  assign rx_valid_o      = rxValid_q;
  assign rx_parity_err_o = rxParErr_q;
  assign rx_frame_err_o  = rxFrameErr_q;

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param
//   Bench for uart_core_param at 10 clocks per bit. Four instances cover the
//   frame formats of interest: 8N1, 8E1, 8O1 and 8N2. Each receiver normally
//   listens to its own transmitter; the bench can invert the looped line or
//   take over the receive line entirely to inject faulty frames.
//
// Ports: none (top-level bench).

module tb_uart_core_param;

  localparam int CF = 1_000_000;
  localparam int BD = 100_000;

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         nBits;
    logic [11:0] expFrame;
    logic       flipPar;
    logic [7:0] expRx;
    logic       expPErr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] txData   [4];
  logic       txValid  [4];
  logic       txReady  [4];
  logic       txOut    [4];
  logic       rxIn     [4];
  logic [7:0] rxData   [4];
  logic       rxValid  [4];
  logic       rxPErr   [4];
  logic       rxFErr   [4];
  logic       rxDrive  [4];
  logic       rxLine   [4];
  logic       rxInv    [4];
  int         vCount   [4];

  int checks;
  int failures;

  vec_t vecs [8];

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each receiver hears its own transmitter unless the bench drives the line.
  for (genvar g = 0; g < 4; g++) begin : gRxLine
    assign rxIn[g] = rxDrive[g] ? rxLine[g] : (txOut[g] ^ rxInv[g]);
  end

  uart_core_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(txData[0]), .tx_valid_i(txValid[0]),
    .tx_ready_o(txReady[0]), .tx_o(txOut[0]), .rx_i(rxIn[0]), .rx_data_o(rxData[0]),
    .rx_valid_o(rxValid[0]), .rx_parity_err_o(rxPErr[0]), .rx_frame_err_o(rxFErr[0]));

  uart_core_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u8e1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(txData[1]), .tx_valid_i(txValid[1]),
    .tx_ready_o(txReady[1]), .tx_o(txOut[1]), .rx_i(rxIn[1]), .rx_data_o(rxData[1]),
    .rx_valid_o(rxValid[1]), .rx_parity_err_o(rxPErr[1]), .rx_frame_err_o(rxFErr[1]));

  uart_core_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u8o1 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(txData[2]), .tx_valid_i(txValid[2]),
    .tx_ready_o(txReady[2]), .tx_o(txOut[2]), .rx_i(rxIn[2]), .rx_data_o(rxData[2]),
    .rx_valid_o(rxValid[2]), .rx_parity_err_o(rxPErr[2]), .rx_frame_err_o(rxFErr[2]));

  uart_core_param #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u8n2 (
    .clk_i(clk), .rst_i(rst), .tx_data_i(txData[3]), .tx_valid_i(txValid[3]),
    .tx_ready_o(txReady[3]), .tx_o(txOut[3]), .rx_i(rxIn[3]), .rx_data_o(rxData[3]),
    .rx_valid_o(rxValid[3]), .rx_parity_err_o(rxPErr[3]), .rx_frame_err_o(rxFErr[3]));

  // Count rx_valid pulses per instance, sampled on the falling edge.
  initial vCount = '{0, 0, 0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rxValid[i]) vCount[i] = vCount[i] + 1;
    end
  end

  // Advance n falling edges, then step just past them so counters are settled.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive n bits (LSB of bits first) onto the bench-owned receive line.
  task automatic driveRxFrame(input int s, input logic [11:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      rxLine[s] = bits[k];
      tick(10);
    end
  endtask

  // Send one word, capture the transmitted frame at mid-bit, count the
  // tx_ready low time and check what the looped-back receiver delivered.
  task automatic applyStimulus(input int idx, input vec_t v);
    int         s;
    int         rdyLow;
    int         base;
    logic [11:0] obs;
    s = v.sel;
    tick(1);
    txData[s]  = v.data;
    txValid[s] = 1'b1;
    tick(1);
    txValid[s] = 1'b0;
    base   = vCount[s];
    rdyLow = 0;
    obs    = '0;
    for (int c = 0; c < v.nBits * 10 + 40; c++) begin
      rxInv[s] = v.flipPar && (c >= 90) && (c < 100);
      if (!txReady[s]) rdyLow++;
      if ((c % 10) == 5 && (c / 10) < v.nBits) obs[c / 10] = txOut[s];
      tick(1);
    end
    rxInv[s] = 1'b0;
    checkOutput($sformatf("vec%0d frame", idx), 32'(obs), 32'(v.expFrame));
    checkOutput($sformatf("vec%0d readyLow", idx), rdyLow, v.nBits * 10);
    checkOutput($sformatf("vec%0d rxValidCount", idx), vCount[s] - base, 1);
    checkOutput($sformatf("vec%0d rxData", idx), 32'(rxData[s]), 32'(v.expRx));
    checkOutput($sformatf("vec%0d parityErr", idx), 32'(rxPErr[s]), 32'(v.expPErr));
    checkOutput($sformatf("vec%0d frameErr", idx), 32'(rxFErr[s]), 0);
  endtask

  initial begin : main
    int         base;
    int         hiRun;
    int         rdyHigh;
    logic [11:0] f1;
    logic [11:0] f2;
    logic       txHist  [280];
    logic       rdyHist [280];
    logic [7:0] rxQ [$];
    vec_t       rv;

    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) begin
      txData[i]  = '0;
      txValid[i] = 1'b0;
      rxDrive[i] = 1'b0;
      rxLine[i]  = 1'b1;
      rxInv[i]   = 1'b0;
    end

    // sel, data, bits, expected frame (LSB = first bit on the line), flip parity, rx word, parity error
    vecs[0] = '{0, 8'h41, 10, {2'b00, 1'b1, 8'h41, 1'b0},       1'b0, 8'h41, 1'b0};
    vecs[1] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0},       1'b0, 8'hA5, 1'b0};
    vecs[2] = '{1, 8'h03, 11, {1'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 1'b0, 8'h03, 1'b0};
    vecs[3] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b0, 8'h07, 1'b0};
    vecs[4] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 1'b1, 8'h07, 1'b1};
    vecs[5] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 1'b0, 8'h07, 1'b0};
    vecs[6] = '{2, 8'h03, 11, {1'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 1'b0, 8'h03, 1'b0};
    vecs[7] = '{3, 8'h3C, 11, {1'b0, 2'b11, 8'h3C, 1'b0},      1'b0, 8'h3C, 1'b0};

    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("reset tx", 32'(txOut[0]), 1);
    checkOutput("reset txReady", 32'(txReady[0]), 1);
    checkOutput("reset rxData", 32'(rxData[0]), 0);
    checkOutput("reset rxValid", 32'(rxValid[0]), 0);
    checkOutput("reset parityErr", 32'(rxPErr[0]), 0);
    checkOutput("reset frameErr", 32'(rxFErr[0]), 0);
    tick(5);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Framing error followed by a held-low line: exactly one frame.
    rxDrive[0] = 1'b1;
    rxLine[0]  = 1'b1;
    tick(20);
    base = vCount[0];
    driveRxFrame(0, {2'b00, 1'b0, 8'h5A, 1'b0}, 10);
    rxLine[0] = 1'b0;
    tick(300);
    checkOutput("break count", vCount[0] - base, 1);
    checkOutput("break rxData", 32'(rxData[0]), 32'h5A);
    checkOutput("break frameErr", 32'(rxFErr[0]), 1);
    checkOutput("break parityErr", 32'(rxPErr[0]), 0);
    rxLine[0] = 1'b1;
    tick(30);
    checkOutput("break release count", vCount[0] - base, 1);
    driveRxFrame(0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10);
    tick(30);
    checkOutput("after break count", vCount[0] - base, 2);
    checkOutput("after break rxData", 32'(rxData[0]), 32'h3C);
    checkOutput("after break frameErr", 32'(rxFErr[0]), 0);

    // A 3-clock glitch is rejected as a false start.
    base = vCount[0];
    rxLine[0] = 1'b0;
    tick(3);
    rxLine[0] = 1'b1;
    tick(30);
    checkOutput("glitch count", vCount[0] - base, 0);
    driveRxFrame(0, {2'b00, 1'b1, 8'h96, 1'b0}, 10);
    tick(30);
    checkOutput("post glitch count", vCount[0] - base, 1);
    checkOutput("post glitch rxData", 32'(rxData[0]), 32'h96);
    rxDrive[0] = 1'b0;
    tick(20);

    // Back-to-back frames with tx_valid held high on the two-stop-bit instance.
    tick(1);
    txData[3]  = 8'h55;
    txValid[3] = 1'b1;
    tick(1);
    txData[3] = 8'hAA;
    rxQ.delete();
    for (int c = 0; c < 280; c++) begin
      if (c == 111) txValid[3] = 1'b0;
      txHist[c]  = txOut[3];
      rdyHist[c] = txReady[3];
      if (rxValid[3]) rxQ.push_back(rxData[3]);
      tick(1);
    end
    f1 = '0;
    f2 = '0;
    for (int k = 0; k < 11; k++) begin
      f1[k] = txHist[10 * k + 5];
      f2[k] = txHist[111 + 10 * k + 5];
    end
    rdyHigh = 0;
    for (int c = 0; c <= 220; c++) begin
      if (rdyHist[c]) rdyHigh++;
    end
    hiRun = 0;
    for (int c = 90; c < 280; c++) begin
      if (!txHist[c]) break;
      hiRun++;
    end
    checkOutput("b2b frame1", 32'(f1), 32'({1'b0, 2'b11, 8'h55, 1'b0}));
    checkOutput("b2b frame2", 32'(f2), 32'({1'b0, 2'b11, 8'hAA, 1'b0}));
    checkOutput("b2b ready gap", rdyHigh, 1);
    checkOutput("b2b ready at 110", 32'(rdyHist[110]), 1);
    checkOutput("b2b stop+idle run", hiRun, 21);
    checkOutput("b2b rx count", rxQ.size(), 2);
    checkOutput("b2b rx first", 32'((rxQ.size() > 0) ? rxQ[0] : 8'h00), 32'h55);
    checkOutput("b2b rx second", 32'((rxQ.size() > 1) ? rxQ[1] : 8'h00), 32'hAA);

    // Reset during data bit 3 of a transmission that is also being received.
    tick(1);
    txData[0]  = 8'hC3;
    txValid[0] = 1'b1;
    tick(1);
    txValid[0] = 1'b0;
    base = vCount[0];
    tick(45);
    checkOutput("midframe tx before reset", 32'(txOut[0]), 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("midframe tx after reset", 32'(txOut[0]), 1);
    checkOutput("midframe ready after reset", 32'(txReady[0]), 1);
    tick(150);
    checkOutput("midframe rx discarded", vCount[0] - base, 0);
    rv = '{0, 8'hC3, 10, {2'b00, 1'b1, 8'hC3, 1'b0}, 1'b0, 8'hC3, 1'b0};
    applyStimulus(8, rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
